// File: rtl/fib_bcd_converter.sv
// Iterative double-dabble converter: one unsigned WIDTH-bit term in, packed BCD plus
// significant-digit count out, one shift per cycle behind valid/ready on both sides.
module fib_bcd_converter #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [3:0]            out_ndigits
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Nibble-local +3 correction; no carry crosses a digit boundary.
    function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] b);
        logic [4*DIGITS-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [3:0] count_digits(input logic [4*DIGITS-1:0] b);
        logic [3:0] n;
        n = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] != 4'd0) n = 4'(i + 1);
        end
        return n;
    endfunction

    state_t                state_q;
    logic [WIDTH-1:0]      bin_q, bin_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   out_bcd_q;
    logic                  out_valid_q;
    logic                  in_ready_q;

    always_comb begin
        bcd_d = '0;
        bin_d = '0;
        {bcd_d, bin_d} = {add3(bcd_q), bin_q} << 1;
        cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            out_bcd_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        bin_q      <= in_data;
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_q <= bin_d;
                    bcd_q <= bcd_d;
                    cnt_q <= cnt_d;
                    // The shift happening on this edge is the final one; publish it directly.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        out_bcd_q   <= bcd_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_bcd     = out_bcd_q;
    assign out_ndigits = count_digits(out_bcd_q);

endmodule
